// File: rtl/pdu_gen_multi_if.sv
// Stream/metadata input bundle and packet/descriptor write bundle for pdu_gen_multi.
// master drives the payload side of each bundle, slave returns the ready/consume signals.
interface pdu_stream_if #(
  parameter int DATA_W  = 512,
  parameter int DSC_Q_W = 8,
  parameter int PKT_Q_W = 13,
  parameter int EMPTY_W = $clog2(DATA_W/8)
) ();
  logic               in_sop;
  logic               in_eop;
  logic [DATA_W-1:0]  in_data;
  logic [EMPTY_W-1:0] in_empty;
  logic               in_valid;
  logic               in_ready;
  logic               in_meta_valid;
  logic [DSC_Q_W-1:0] in_meta_dsc_q;
  logic [PKT_Q_W-1:0] in_meta_pkt_q;
  logic               in_meta_ready;

  modport master (
    output in_sop, in_eop, in_data, in_empty, in_valid,
    output in_meta_valid, in_meta_dsc_q, in_meta_pkt_q,
    input  in_ready, in_meta_ready
  );

  modport slave (
    input  in_sop, in_eop, in_data, in_empty, in_valid,
    input  in_meta_valid, in_meta_dsc_q, in_meta_pkt_q,
    output in_ready, in_meta_ready
  );
endinterface

interface pdu_wr_if #(
  parameter int DATA_W  = 512,
  parameter int DSC_Q_W = 8,
  parameter int PKT_Q_W = 13
) ();
  logic [DATA_W-1:0]  pkt_wr_data;
  logic               pkt_wr_sop;
  logic               pkt_wr_eop;
  logic               pkt_wr_en;
  logic               pkt_buf_in_ready;
  logic [DSC_Q_W-1:0] dsc_wr_dsc_q;
  logic [PKT_Q_W-1:0] dsc_wr_pkt_q;
  logic [15:0]        dsc_wr_size_bytes;
  logic [15:0]        dsc_wr_size_flits;
  logic               dsc_wr_trunc;
  logic               dsc_wr_en;
  logic               dsc_buf_in_ready;

  modport master (
    output pkt_wr_data, pkt_wr_sop, pkt_wr_eop, pkt_wr_en,
    output dsc_wr_dsc_q, dsc_wr_pkt_q, dsc_wr_size_bytes, dsc_wr_size_flits,
    output dsc_wr_trunc, dsc_wr_en,
    input  pkt_buf_in_ready, dsc_buf_in_ready
  );

  modport slave (
    input  pkt_wr_data, pkt_wr_sop, pkt_wr_eop, pkt_wr_en,
    input  dsc_wr_dsc_q, dsc_wr_pkt_q, dsc_wr_size_bytes, dsc_wr_size_flits,
    input  dsc_wr_trunc, dsc_wr_en,
    output pkt_buf_in_ready, dsc_buf_in_ready
  );
endinterface

// File: rtl/pdu_gen_multi.sv
// Framed RX stream to PCIe packet-buffer flits plus one descriptor per packet,
// with truncation of oversize packets, framing-error recovery and saturating statistics.
module pdu_gen_multi #(
  parameter int DATA_W        = 512,
  parameter int BYTE_SWAP     = 1,
  parameter int MAX_PKT_FLITS = 150,
  parameter int DSC_Q_W       = 8,
  parameter int PKT_Q_W       = 13,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  pdu_stream_if.slave      rx,
  pdu_wr_if.master         tx,
  output logic [CNT_W-1:0] stat_pkts,
  output logic [CNT_W-1:0] stat_trunc,
  output logic [CNT_W-1:0] stat_err
);

  localparam int          BYTES_PER_FLIT = DATA_W / 8;
  localparam logic [15:0] FLIT_BYTES     = 16'(BYTES_PER_FLIT);
  localparam logic [15:0] MAX_FLITS      = 16'(MAX_PKT_FLITS);

  if ((DATA_W % 8) != 0 || DATA_W < 16) begin : g_width_chk
    $error("pdu_gen_multi: DATA_W must be a multiple of 8 and at least 16");
  end
  if (MAX_PKT_FLITS < 1 || (MAX_PKT_FLITS * BYTES_PER_FLIT) >= 65536) begin : g_size_chk
    $error("pdu_gen_multi: MAX_PKT_FLITS * DATA_W/8 must fit in 16 bits");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IN_PKT  = 2'd1,
    DISCARD = 2'd2
  } state_t;

  // Reverse byte order so that byte 0 lands in the top byte lane.
  function automatic logic [DATA_W-1:0] swap_bytes(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] res;
    res = '0;
    for (int i = 0; i < BYTES_PER_FLIT; i++) begin
      res[i*8 +: 8] = d[(BYTES_PER_FLIT-1-i)*8 +: 8];
    end
    return res;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    logic [CNT_W-1:0] res;
    if (&c) begin
      res = c;
    end else begin
      res = c + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  state_t             state_r;
  logic [15:0]        flits_r;
  logic [15:0]        bytes_r;
  logic [DATA_W-1:0]  pkt_wr_data_r;
  logic               pkt_wr_sop_r;
  logic               pkt_wr_eop_r;
  logic               pkt_wr_en_r;
  logic [DSC_Q_W-1:0] dsc_wr_dsc_q_r;
  logic [PKT_Q_W-1:0] dsc_wr_pkt_q_r;
  logic [15:0]        dsc_wr_size_bytes_r;
  logic [15:0]        dsc_wr_size_flits_r;
  logic               dsc_wr_trunc_r;
  logic               dsc_wr_en_r;
  logic               meta_ready_r;
  logic [CNT_W-1:0]   stat_pkts_r;
  logic [CNT_W-1:0]   stat_trunc_r;
  logic [CNT_W-1:0]   stat_err_r;

  logic               in_ready_s;
  logic               acc_s;
  logic               start_s;
  logic               cont_s;
  logic               err_s;
  logic               drop_end_s;
  logic               write_s;
  logic               trunc_s;
  logic               finish_s;
  logic [15:0]        new_flits_s;
  logic [15:0]        base_bytes_s;
  logic [15:0]        size_s;
  logic [DATA_W-1:0]  out_data_s;

  assign rx.in_ready         = in_ready_s;
  assign rx.in_meta_ready    = meta_ready_r;
  assign tx.pkt_wr_data      = pkt_wr_data_r;
  assign tx.pkt_wr_sop       = pkt_wr_sop_r;
  assign tx.pkt_wr_eop       = pkt_wr_eop_r;
  assign tx.pkt_wr_en        = pkt_wr_en_r;
  assign tx.dsc_wr_dsc_q     = dsc_wr_dsc_q_r;
  assign tx.dsc_wr_pkt_q     = dsc_wr_pkt_q_r;
  assign tx.dsc_wr_size_bytes = dsc_wr_size_bytes_r;
  assign tx.dsc_wr_size_flits = dsc_wr_size_flits_r;
  assign tx.dsc_wr_trunc     = dsc_wr_trunc_r;
  assign tx.dsc_wr_en        = dsc_wr_en_r;
  assign stat_pkts           = stat_pkts_r;
  assign stat_trunc          = stat_trunc_r;
  assign stat_err            = stat_err_r;

  // Decode the accepted flit into write / finish / truncate / error events.
  always_comb begin
    in_ready_s   = tx.pkt_buf_in_ready & tx.dsc_buf_in_ready;
    acc_s        = rx.in_valid & rx.in_meta_valid & in_ready_s;
    start_s      = 1'b0;
    cont_s       = 1'b0;
    err_s        = 1'b0;
    drop_end_s   = 1'b0;
    case (state_r)
      IDLE: begin
        start_s = acc_s & rx.in_sop;
        err_s   = acc_s & ~rx.in_sop;
      end
      IN_PKT: begin
        // A fresh sop abandons the unfinished packet and restarts on this flit.
        start_s = acc_s & rx.in_sop;
        cont_s  = acc_s & ~rx.in_sop;
        err_s   = acc_s & rx.in_sop;
      end
      DISCARD: begin
        drop_end_s = acc_s & rx.in_eop;
      end
      default: begin
        start_s = 1'b0;
      end
    endcase
    write_s = start_s | cont_s;
    if (start_s) begin
      new_flits_s  = 16'd1;
      base_bytes_s = FLIT_BYTES;
    end else begin
      new_flits_s  = flits_r + 16'd1;
      base_bytes_s = bytes_r + FLIT_BYTES;
    end
    trunc_s  = write_s & ~rx.in_eop & (new_flits_s == MAX_FLITS);
    finish_s = write_s & (rx.in_eop | trunc_s);
    if (trunc_s) begin
      size_s = base_bytes_s;
    end else begin
      size_s = base_bytes_s - 16'(rx.in_empty);
    end
    if (BYTE_SWAP != 0) begin
      out_data_s = swap_bytes(rx.in_data);
    end else begin
      out_data_s = rx.in_data;
    end
  end

  // Packet FSM, running totals, registered write/descriptor outputs and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r             <= IDLE;
      flits_r             <= 16'd0;
      bytes_r             <= 16'd0;
      pkt_wr_data_r       <= '0;
      pkt_wr_sop_r        <= 1'b0;
      pkt_wr_eop_r        <= 1'b0;
      pkt_wr_en_r         <= 1'b0;
      dsc_wr_dsc_q_r      <= '0;
      dsc_wr_pkt_q_r      <= '0;
      dsc_wr_size_bytes_r <= 16'd0;
      dsc_wr_size_flits_r <= 16'd0;
      dsc_wr_trunc_r      <= 1'b0;
      dsc_wr_en_r         <= 1'b0;
      meta_ready_r        <= 1'b0;
      stat_pkts_r         <= '0;
      stat_trunc_r        <= '0;
      stat_err_r          <= '0;
    end else begin
      pkt_wr_en_r  <= write_s;
      pkt_wr_sop_r <= start_s;
      pkt_wr_eop_r <= finish_s;
      dsc_wr_en_r  <= finish_s;
      // A truncated packet keeps its metadata until its real eop is drained.
      meta_ready_r <= (finish_s & ~trunc_s) | drop_end_s;
      if (write_s) begin
        pkt_wr_data_r <= out_data_s;
        flits_r       <= new_flits_s;
        bytes_r       <= base_bytes_s;
      end
      if (finish_s) begin
        dsc_wr_dsc_q_r      <= rx.in_meta_dsc_q;
        dsc_wr_pkt_q_r      <= rx.in_meta_pkt_q;
        dsc_wr_size_bytes_r <= size_s;
        dsc_wr_size_flits_r <= new_flits_s;
        dsc_wr_trunc_r      <= trunc_s;
        stat_pkts_r         <= sat_inc(stat_pkts_r);
      end
      if (trunc_s) begin
        stat_trunc_r <= sat_inc(stat_trunc_r);
      end
      if (err_s) begin
        stat_err_r <= sat_inc(stat_err_r);
      end
      case (state_r)
        IDLE, IN_PKT: begin
          if (finish_s) begin
            state_r <= trunc_s ? DISCARD : IDLE;
          end else if (write_s) begin
            state_r <= IN_PKT;
          end else begin
            state_r <= state_r;
          end
        end
        DISCARD: begin
          if (drop_end_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= DISCARD;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pdu_gen_multi.sv
// Directed bench for pdu_gen_multi (DATA_W=512, BYTE_SWAP=1, MAX_PKT_FLITS=4) with immediate-assertion checks.
module tb_pdu_gen_multi;

  localparam int DATA_W  = 512;
  localparam int DSC_Q_W = 8;
  localparam int PKT_Q_W = 13;
  localparam int CNT_W   = 32;

  logic clk;
  logic rst;
  logic [CNT_W-1:0] stat_pkts;
  logic [CNT_W-1:0] stat_trunc;
  logic [CNT_W-1:0] stat_err;
  int n_assert;
  int n_fail;
  logic [DATA_W-1:0] d;

  pdu_stream_if #(.DATA_W(DATA_W), .DSC_Q_W(DSC_Q_W), .PKT_Q_W(PKT_Q_W)) rx ();
  pdu_wr_if     #(.DATA_W(DATA_W), .DSC_Q_W(DSC_Q_W), .PKT_Q_W(PKT_Q_W)) tx ();

  pdu_gen_multi #(
    .DATA_W(DATA_W), .BYTE_SWAP(1), .MAX_PKT_FLITS(4),
    .DSC_Q_W(DSC_Q_W), .PKT_Q_W(PKT_Q_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx.slave), .tx(tx.master),
    .stat_pkts(stat_pkts), .stat_trunc(stat_trunc), .stat_err(stat_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one flit, let it be clocked in, and return 1 time unit after the edge.
  task automatic send(input logic s, input logic e, input logic [DATA_W-1:0] dat, input logic [5:0] emp);
    rx.in_sop   = s;
    rx.in_eop   = e;
    rx.in_data  = dat;
    rx.in_empty = emp;
    rx.in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    rx.in_valid = 1'b0;
    rx.in_sop   = 1'b0;
    rx.in_eop   = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1;
    rx.in_sop = 1'b0; rx.in_eop = 1'b0; rx.in_data = '0; rx.in_empty = 6'd0;
    rx.in_valid = 1'b0; rx.in_meta_valid = 1'b1;
    rx.in_meta_dsc_q = 8'h11; rx.in_meta_pkt_q = 13'h0abc;
    tx.pkt_buf_in_ready = 1'b1; tx.dsc_buf_in_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_pkt_wr_en", 64'(tx.pkt_wr_en), 64'd0);
    chk("rst_dsc_wr_en", 64'(tx.dsc_wr_en), 64'd0);
    chk("rst_meta_ready", 64'(rx.in_meta_ready), 64'd0);
    chk("rst_stat_pkts", 64'(stat_pkts), 64'd0);
    chk("rst_data", tx.pkt_wr_data[63:0], 64'd0);
    chk("in_ready_up", 64'(rx.in_ready), 64'd1);

    // 1: single-flit packet, empty=4
    d = '0; d[7:0] = 8'h3c;
    send(1'b1, 1'b1, d, 6'd4);
    chk("t1_wr_en", 64'(tx.pkt_wr_en), 64'd1);
    chk("t1_sop_eop", 64'({tx.pkt_wr_sop, tx.pkt_wr_eop}), 64'd3);
    chk("t1_dsc_en", 64'(tx.dsc_wr_en), 64'd1);
    chk("t1_bytes", 64'(tx.dsc_wr_size_bytes), 64'd60);
    chk("t1_flits", 64'(tx.dsc_wr_size_flits), 64'd1);
    chk("t1_ids", 64'({tx.dsc_wr_dsc_q, tx.dsc_wr_pkt_q}), 64'({8'h11, 13'h0abc}));
    chk("t1_meta_ready", 64'(rx.in_meta_ready), 64'd1);
    idle_cycle();
    chk("t1_meta_pulse_end", 64'(rx.in_meta_ready), 64'd0);
    chk("t1_wr_en_end", 64'(tx.pkt_wr_en), 64'd0);

    // 2: three-flit packet, byte swap
    rx.in_meta_dsc_q = 8'h22; rx.in_meta_pkt_q = 13'h1234;
    d = '0; d[7:0] = 8'hAA; d[511:504] = 8'h55;
    send(1'b1, 1'b0, d, 6'd0);
    chk("t2_swap_top", 64'(tx.pkt_wr_data[511:504]), 64'hAA);
    chk("t2_swap_bot", 64'(tx.pkt_wr_data[7:0]), 64'h55);
    chk("t2_f1_sop_eop", 64'({tx.pkt_wr_sop, tx.pkt_wr_eop}), 64'd2);
    chk("t2_f1_dsc_en", 64'(tx.dsc_wr_en), 64'd0);
    send(1'b0, 1'b0, d, 6'd0);
    chk("t2_f2_sop_eop", 64'({tx.pkt_wr_en, tx.pkt_wr_sop, tx.pkt_wr_eop}), 64'd4);
    send(1'b0, 1'b1, d, 6'd0);
    chk("t2_f3_eop", 64'(tx.pkt_wr_eop), 64'd1);
    chk("t2_bytes", 64'(tx.dsc_wr_size_bytes), 64'd192);
    chk("t2_flits", 64'(tx.dsc_wr_size_flits), 64'd3);
    chk("t2_ids", 64'({tx.dsc_wr_dsc_q, tx.dsc_wr_pkt_q}), 64'({8'h22, 13'h1234}));
    chk("t2_stat_pkts", 64'(stat_pkts), 64'd2);

    // 3: six-flit packet truncated at four
    send(1'b1, 1'b0, d, 6'd0);
    send(1'b0, 1'b0, d, 6'd0);
    send(1'b0, 1'b0, d, 6'd0);
    chk("t3_f3_no_dsc", 64'(tx.dsc_wr_en), 64'd0);
    send(1'b0, 1'b0, d, 6'd0);
    chk("t3_f4_wr_eop", 64'({tx.pkt_wr_en, tx.pkt_wr_eop}), 64'd3);
    chk("t3_dsc_en", 64'(tx.dsc_wr_en), 64'd1);
    chk("t3_trunc", 64'(tx.dsc_wr_trunc), 64'd1);
    chk("t3_bytes", 64'(tx.dsc_wr_size_bytes), 64'd256);
    chk("t3_flits", 64'(tx.dsc_wr_size_flits), 64'd4);
    chk("t3_meta_held", 64'(rx.in_meta_ready), 64'd0);
    chk("t3_stat_trunc", 64'(stat_trunc), 64'd1);
    send(1'b0, 1'b0, d, 6'd0);
    chk("t3_f5_dropped", 64'({tx.pkt_wr_en, tx.dsc_wr_en}), 64'd0);
    send(1'b0, 1'b1, d, 6'd10);
    chk("t3_f6_dropped", 64'({tx.pkt_wr_en, tx.dsc_wr_en}), 64'd0);
    chk("t3_f6_meta", 64'(rx.in_meta_ready), 64'd1);
    chk("t3_stat_pkts", 64'(stat_pkts), 64'd3);

    // 4: sop, data, sop, eop -> one framing error, descriptor for second packet only
    send(1'b1, 1'b0, d, 6'd0);
    send(1'b0, 1'b0, d, 6'd0);
    send(1'b1, 1'b0, d, 6'd0);
    chk("t4_restart_sop", 64'({tx.pkt_wr_en, tx.pkt_wr_sop, tx.dsc_wr_en}), 64'd6);
    chk("t4_stat_err", 64'(stat_err), 64'd1);
    send(1'b0, 1'b1, d, 6'd0);
    chk("t4_dsc_en", 64'(tx.dsc_wr_en), 64'd1);
    chk("t4_flits", 64'(tx.dsc_wr_size_flits), 64'd2);
    chk("t4_bytes", 64'(tx.dsc_wr_size_bytes), 64'd128);
    chk("t4_trunc", 64'(tx.dsc_wr_trunc), 64'd0);
    chk("t4_stat_pkts", 64'(stat_pkts), 64'd4);

    // 5: descriptor buffer stalls mid-packet for 3 cycles
    send(1'b1, 1'b0, d, 6'd0);
    d = '0; d[7:0] = 8'h77;
    rx.in_sop = 1'b0; rx.in_eop = 1'b0; rx.in_data = d;
    tx.dsc_buf_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("t5_in_ready_low", 64'(rx.in_ready), 64'd0);
      chk("t5_no_write", 64'(tx.pkt_wr_en), 64'd0);
    end
    tx.dsc_buf_in_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_resume_wr", 64'({tx.pkt_wr_en, tx.pkt_wr_sop}), 64'd2);
    chk("t5_resume_data", 64'(tx.pkt_wr_data[511:504]), 64'h77);
    send(1'b0, 1'b1, d, 6'd2);
    chk("t5_flits", 64'(tx.dsc_wr_size_flits), 64'd3);
    chk("t5_bytes", 64'(tx.dsc_wr_size_bytes), 64'd190);
    chk("t5_stat_pkts", 64'(stat_pkts), 64'd5);

    // 6: reset mid-packet, then a flit without sop
    send(1'b1, 1'b0, d, 6'd0);
    rx.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("t6_rst_wr_en", 64'(tx.pkt_wr_en), 64'd0);
    chk("t6_rst_stats", 64'({stat_pkts, stat_err}), 64'd0);
    chk("t6_rst_trunc", 64'(stat_trunc), 64'd0);
    send(1'b0, 1'b0, d, 6'd0);
    chk("t6_dropped", 64'({tx.pkt_wr_en, tx.dsc_wr_en}), 64'd0);
    chk("t6_stat_err", 64'(stat_err), 64'd1);
    send(1'b1, 1'b1, d, 6'd0);
    chk("t6_fresh_pkt", 64'({tx.pkt_wr_sop, tx.pkt_wr_eop, tx.dsc_wr_en}), 64'd7);
    chk("t6_fresh_bytes", 64'(tx.dsc_wr_size_bytes), 64'd64);
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
